// File: rtl/regfile_io.sv
// regfile_io: picoMIPS register file. %0 reads zero, %1 is a handshaked
// input-port register, %2 is an output port backed by a FIFO, and the
// remaining addresses are general-purpose registers.
module regfile_io #(
  parameter int unsigned N         = 8,
  parameter int unsigned NREGS     = 8,
  parameter int unsigned AW        = $clog2(NREGS),
  parameter int unsigned OUT_DEPTH = 4
) (
  input  logic          clk,
  input  logic          nrst,
  input  logic          w,
  input  logic [N-1:0]  write_data,
  input  logic [AW-1:0] r_dest,
  input  logic [AW-1:0] r_source,
  input  logic          in_consume,
  output logic [N-1:0]  rd_data,
  output logic [N-1:0]  rs_data,
  input  logic [N-1:0]  in_data,
  input  logic          in_valid,
  output logic          in_ready,
  output logic [N-1:0]  out_data,
  output logic          out_valid,
  input  logic          out_ready,
  output logic          stall
);

  localparam int unsigned PW = (OUT_DEPTH > 1) ? $clog2(OUT_DEPTH) : 1;
  localparam int unsigned CW = $clog2(OUT_DEPTH + 1);

  logic [N-1:0]  gpr_q [NREGS];
  logic [N-1:0]  fifo_q [OUT_DEPTH];
  logic [N-1:0]  last_out_q;
  logic [N-1:0]  in_reg_q;
  logic          in_full_q, in_full_d;
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] cnt_q, cnt_d;

  logic fifo_full, push, pop, gpr_we, capture, consume;

  // Pointer advance wrapping modulo OUT_DEPTH (also correct for depth 1).
  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(OUT_DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  // Address decode shared by both read ports.
  function automatic logic [N-1:0] decode(input logic [AW-1:0] a,
                                          input logic [N-1:0]  in_word,
                                          input logic [N-1:0]  last_word,
                                          input logic [N-1:0]  gpr_word);
    if (a == AW'(0))      return '0;
    else if (a == AW'(1)) return in_word;
    else if (a == AW'(2)) return last_word;
    else                  return gpr_word;
  endfunction

  // Combinational read ports; no write-to-read bypass.
  always_comb begin
    rd_data = decode(r_dest,   in_reg_q, last_out_q, gpr_q[r_dest]);
    rs_data = decode(r_source, in_reg_q, last_out_q, gpr_q[r_source]);
  end

  // Handshake outputs, stall, and next-state for the control registers.
  always_comb begin
    fifo_full = (cnt_q == CW'(OUT_DEPTH));
    in_ready  = !in_full_q;
    out_valid = (cnt_q != '0);
    out_data  = out_valid ? fifo_q[rd_ptr_q] : '0;
    stall     = (w && (r_dest == AW'(2)) && fifo_full) || (in_consume && !in_full_q);

    push    = w && !stall && (r_dest == AW'(2));
    gpr_we  = w && !stall && (r_dest > AW'(2));
    pop     = out_valid && out_ready;
    capture = in_valid && !in_full_q;
    consume = in_consume && in_full_q && !stall;

    wr_ptr_d  = push ? ptr_inc(wr_ptr_q) : wr_ptr_q;
    rd_ptr_d  = pop  ? ptr_inc(rd_ptr_q) : rd_ptr_q;
    cnt_d     = cnt_q;
    if (push && !pop)      cnt_d = cnt_q + CW'(1);
    else if (pop && !push) cnt_d = cnt_q - CW'(1);

    in_full_d = in_full_q;
    if (capture)      in_full_d = 1'b1;
    else if (consume) in_full_d = 1'b0;
  end

  // State update; reset discards all contents including in-flight FIFO data.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      for (int i = 0; i < int'(NREGS); i++)     gpr_q[i]  <= '0;
      for (int i = 0; i < int'(OUT_DEPTH); i++) fifo_q[i] <= '0;
      last_out_q <= '0;
      in_reg_q   <= '0;
      in_full_q  <= 1'b0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      cnt_q      <= '0;
    end else begin
      if (gpr_we) gpr_q[r_dest] <= write_data;
      if (push) begin
        fifo_q[wr_ptr_q] <= write_data;
        last_out_q       <= write_data;
      end
      if (capture) in_reg_q <= in_data;
      in_full_q <= in_full_d;
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      cnt_q     <= cnt_d;
    end
  end

endmodule

// File: tb/tb_regfile_io.sv
// Directed bench for regfile_io: GPRs, input handshake, output FIFO, reset.
module tb_regfile_io;

  logic       clk = 1'b0;
  logic       nrst;
  logic       w;
  logic [7:0] write_data;
  logic [2:0] r_dest, r_source;
  logic       in_consume;
  logic [7:0] rd_data, rs_data;
  logic [7:0] in_data;
  logic       in_valid, in_ready;
  logic [7:0] out_data;
  logic       out_valid, out_ready;
  logic       stall;

  int passed = 0;
  int total  = 0;

  regfile_io dut (
    .clk(clk), .nrst(nrst), .w(w), .write_data(write_data),
    .r_dest(r_dest), .r_source(r_source), .in_consume(in_consume),
    .rd_data(rd_data), .rs_data(rs_data), .in_data(in_data),
    .in_valid(in_valid), .in_ready(in_ready), .out_data(out_data),
    .out_valid(out_valid), .out_ready(out_ready), .stall(stall)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
  endtask

  // Apply one rising edge, then settle so checks sit mid-cycle.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [2:0] a, input logic [7:0] d);
    w = 1'b1; r_dest = a; write_data = d;
    tick();
    w = 1'b0;
  endtask

  initial begin
    nrst = 1'b0; w = 1'b0; write_data = '0; r_dest = '0; r_source = '0;
    in_consume = 1'b0; in_data = '0; in_valid = 1'b0; out_ready = 1'b0;
    tick(); tick();
    nrst = 1'b1;
    #1;

    // Reset state: every address reads zero, ports idle.
    for (int a = 0; a < 8; a++) begin
      r_dest = 3'(a); r_source = 3'(a); #1;
      chk($sformatf("rst_rd%0d", a), rd_data, 8'h00);
      chk($sformatf("rst_rs%0d", a), rs_data, 8'h00);
    end
    chk("rst_in_ready", 8'(in_ready), 8'h01);
    chk("rst_out_valid", 8'(out_valid), 8'h00);
    chk("rst_out_data", out_data, 8'h00);
    chk("rst_stall", 8'(stall), 8'h00);

    // GPR writes and %0 hard-wired zero.
    wr(3'd3, 8'hA5);
    wr(3'd7, 8'h3C);
    r_dest = 3'd3; r_source = 3'd7; #1;
    chk("gpr3", rd_data, 8'hA5);
    chk("gpr7", rs_data, 8'h3C);
    wr(3'd0, 8'hFF);
    r_dest = 3'd0; #1;
    chk("r0_zero", rd_data, 8'h00);

    // Input port handshake.
    in_data = 8'h42; in_valid = 1'b1; #1;
    chk("in_ready_pre", 8'(in_ready), 8'h01);
    tick();
    in_valid = 1'b0; r_dest = 3'd1; #1;
    chk("in_ready_full", 8'(in_ready), 8'h00);
    chk("in_reg", rd_data, 8'h42);
    in_consume = 1'b1; #1;
    chk("consume_nostall", 8'(stall), 8'h00);
    tick();
    in_consume = 1'b0; #1;
    chk("in_ready_after", 8'(in_ready), 8'h01);
    // Consume while empty stalls and blocks a simultaneous GPR write.
    in_consume = 1'b1; w = 1'b1; r_dest = 3'd4; write_data = 8'h99; #1;
    chk("consume_empty_stall", 8'(stall), 8'h01);
    tick();
    in_consume = 1'b0; w = 1'b0; #1;
    chk("stall_no_write", rd_data, 8'h00);
    chk("stall_in_ready", 8'(in_ready), 8'h01);

    // Fill FIFO, fifth write stalls, then drain with pointer wrap.
    out_ready = 1'b0;
    wr(3'd2, 8'h01);
    chk("fifo_valid1", 8'(out_valid), 8'h01);
    chk("fifo_head1", out_data, 8'h01);
    wr(3'd2, 8'h02);
    wr(3'd2, 8'h03);
    wr(3'd2, 8'h04);
    w = 1'b1; r_dest = 3'd2; write_data = 8'h05; #1;
    chk("full_stall", 8'(stall), 8'h01);
    tick();
    chk("last_out4", rd_data, 8'h04);
    chk("still_stall", 8'(stall), 8'h01);
    out_ready = 1'b1; #1;
    chk("stall_with_pop", 8'(stall), 8'h01);
    chk("pop1", out_data, 8'h01);
    tick();
    chk("retry_nostall", 8'(stall), 8'h00);
    chk("pop2", out_data, 8'h02);
    tick();
    w = 1'b0; #1;
    chk("pop3", out_data, 8'h03);
    tick();
    chk("pop4", out_data, 8'h04);
    tick();
    chk("pop5", out_data, 8'h05);
    chk("last_out5", rd_data, 8'h05);
    tick();
    chk("drained_valid", 8'(out_valid), 8'h00);
    chk("drained_data", out_data, 8'h00);

    // Simultaneous push and pop on a one-entry FIFO.
    out_ready = 1'b0;
    wr(3'd2, 8'h11);
    out_ready = 1'b1; w = 1'b1; r_dest = 3'd2; write_data = 8'h77; #1;
    chk("pp_head_old", out_data, 8'h11);
    tick();
    w = 1'b0; out_ready = 1'b0; #1;
    chk("pp_valid", 8'(out_valid), 8'h01);
    chk("pp_head_new", out_data, 8'h77);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0; #1;
    chk("pp_count1", 8'(out_valid), 8'h00);

    // Asynchronous reset mid-stream.
    wr(3'd2, 8'h0A);
    wr(3'd2, 8'h0B);
    in_data = 8'h55; in_valid = 1'b1;
    wr(3'd2, 8'h0C);
    in_valid = 1'b0;
    wr(3'd5, 8'h66);
    chk("pre_rst_in_ready", 8'(in_ready), 8'h00);
    chk("pre_rst_out_valid", 8'(out_valid), 8'h01);
    nrst = 1'b0; #1;
    chk("async_out_valid", 8'(out_valid), 8'h00);
    chk("async_in_ready", 8'(in_ready), 8'h01);
    tick();
    nrst = 1'b1;
    tick();
    for (int a = 0; a < 8; a++) begin
      r_dest = 3'(a); r_source = 3'(7 - a); #1;
      chk($sformatf("rst2_rd%0d", a), rd_data, 8'h00);
      chk($sformatf("rst2_rs%0d", 7 - a), rs_data, 8'h00);
    end
    chk("rst2_out_data", out_data, 8'h00);
    chk("rst2_stall", 8'(stall), 8'h00);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/regfile_io.md
# regfile_io

Parametrised picoMIPS register file with handshaked I/O, the successor to the fixed 8-register file with a raw in/out port. It holds `NREGS` general-purpose registers of `N` bits with %0 hard-wired to zero. %1 is a latched input-port register with a valid/ready handshake, and %2 is an output port backed by a FIFO. When an access cannot complete, a `stall` output tells the picoMIPS control unit to hold the current instruction.

## Interface
Parameters:
- `N`, 8: data width in bits.
- `NREGS`, 8: number of architectural registers (≥4, power of 2).
- `AW`, $clog2(NREGS): register-address width (derived; not overridden).
- `OUT_DEPTH`, 4: output FIFO depth (≥1, power of 2).

Ports:
- `clk`  in  1  system clock; all state changes on rising edge.
- `nrst`  in  1  asynchronous active-low reset.
- `w`  in  1  register write enable.
- `write_data`  in  N  data written to `r_dest`.
- `r_dest`  in  AW  destination register; also read register A.
- `r_source`  in  AW  source register; read register B.
- `in_consume`  in  1  current instruction consumes %1.
- `rd_data`  out  N  combinational read of `r_dest`.
- `rs_data`  out  N  combinational read of `r_source`.
- `in_data`  in  N  input-port word.
- `in_valid`  in  1  `in_data` valid.
- `in_ready`  out  1  input register empty; can accept a word.
- `out_data`  out  N  FIFO head word.
- `out_valid`  out  1  FIFO non-empty.
- `out_ready`  in  1  sink accepts `out_data`.
- `stall`  out  1  instruction cannot complete this cycle.

## Operation
- Read decode, same for both read ports:
  - %0 reads 0.
  - %1 reads the input-register contents.
  - %2 reads `last_out`, the last word successfully written to %2.
  - Any other address reads `gpr[addr]`.
- The read paths are purely combinational. There is no write-to-read bypass: a write is visible on the cycle after the edge.
- `stall = (w && r_dest==2 && fifo_full) || (in_consume && !in_full)`.
- When `stall`=1, no CPU-side state changes: no GPR write, no FIFO push, no `last_out` update, and no consume. Sink pops and input captures still proceed.
- Write handling, when `w` and `!stall`:
  - Writes to %0 and %1 are ignored.
  - A write to %2 pushes `write_data` into the FIFO and updates `last_out`.
  - A write to any other address updates `gpr[r_dest]`.
- Input register:
  - `in_ready = !in_full`, derived only from the register; there is no combinational pass-through.
  - A word is captured when `in_valid && in_ready`; capture sets `in_full`.
  - `in_consume && in_full && !stall` clears `in_full`.
  - Consume and capture cannot coincide, because capture needs `in_full`=0.
- Output FIFO:
  - Circular buffer with write/read pointers wrapping modulo `OUT_DEPTH`.
  - The count is $clog2(OUT_DEPTH+1) bits wide.
  - A pop happens when `out_valid && out_ready`.
  - Push and pop in the same cycle leave the count unchanged.
  - When the FIFO is full, a push stalls even if a pop occurs that cycle.
  - When the FIFO is empty, `out_data` = 0.
- Reset:
  - All GPRs, `last_out`, the FIFO pointers and count, `in_full` and the input register clear to 0.
  - Outputs after reset: `in_ready`=1, `out_valid`=0, `out_data`=0, `stall`=0. `rd_data`/`rs_data` follow the decode, giving 0 for every address.
  - An asserted reset aborts any in-flight transfer immediately; the FIFO contents are lost.

## Timing
- Write latency is one cycle: data written at edge k is readable in the cycle after edge k.
- Input latency is one cycle from an `in_valid`/`in_ready` handshake to valid %1 read data.
- Output latency is one cycle from the %2 write edge to `out_valid`=1 (when the FIFO was empty).
- `stall` is combinational from `w`, `r_dest` and `in_consume` to the output within the same cycle. `in_ready` and `out_valid` are purely registered-derived.
- FIFO throughput is one push plus one pop per cycle.

## Test plan
- Reset, then read all addresses -> `rd_data`=`rs_data`=0; `in_ready`=1, `out_valid`=0, `stall`=0.
- Write 8'hA5 to %3 and 8'h3C to %7, then read both on r_dest/r_source -> A5/3C next cycle. A write of 8'hFF to %0 -> %0 still reads 0.
- Drive `in_data`=8'h42 with `in_valid`=1:
  - `in_ready` drops next cycle and %1 reads 42.
  - `in_consume` -> `in_ready`=1 the following cycle.
  - `in_consume` while empty -> `stall`=1 and no state change.
- With `out_ready`=0, write 1,2,3,4 to %2, then 5 -> `stall`=1 on the fifth write and %2 reads 4. Then `out_ready`=1 -> pops 1,2,3,4 in order, and the retried 5 appears last (pointer wrap exercised).
- FIFO holding 1 entry with `out_ready`=1 and a %2 write of 8'h77 in the same cycle -> count stays 1, and `out_data` moves to 77.
- Assert `nrst` mid-stream, with the FIFO at 3 entries and `in_full`=1 -> the next cycle shows `out_valid`=0, `in_ready`=1 and all registers 0.
